// File: rtl/mfp_ahb_sevenseg_scan.sv
// -----------------------------------------------------------------------------
// mfp_ahb_sevenseg_scan
//
// Time-multiplexing scan controller for an 8-digit seven-segment display.
// Walks round-robin over the enabled digits. Every digit slot starts with a
// ghost-guard gap (all anodes off), followed by the show window. Blinking
// digits are dark during alternate blink half-periods. One blink half-period
// is BLINK_SCANS scan wraps.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   digen      [7:0]  digit enable, 1 = digit takes part in the scan
//   numbers    [39:0] 5-bit decoder code per digit, digit i in [5i+4:5i]
//   dp_n       [7:0]  active-low decimal point per digit (code bit 5)
//   blink      [7:0]  1 = digit blinks
//   an         [7:0]  active-low anode enables, at most one low
//   dec_data   [5:0]  {dp_n[i], numbers[i]} to the decoder, 6'h3F when dark
//   scan_wrap         one-cycle pulse on the first show cycle of a wrap slot
//   cur_digit  [2:0]  index of the last selected digit
//
// state | meaning
// ------+----------------------------------------------------------------
// BLANK | ghost guard, all anodes off; next digit picked on last cycle
// SHOW  | selected digit driven (or kept dark while blinking)
// IDLE  | no digit enabled, display dark, cur_digit held
// -----------------------------------------------------------------------------
module mfp_ahb_sevenseg_scan #(
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_SCANS  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  digen,
    input  logic [39:0] numbers,
    input  logic [7:0]  dp_n,
    input  logic [7:0]  blink,
    output logic [7:0]  an,
    output logic [5:0]  dec_data,
    output logic        scan_wrap,
    output logic [2:0]  cur_digit
);

    localparam int CW          = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int WW          = $clog2(BLINK_SCANS + 1);
    localparam int SHOW_CYCLES = PRESCALE - BLANK_CYCLES;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
    localparam logic [WW-1:0] WRAP_LAST  = WW'(BLINK_SCANS - 1);

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_SHOW  = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [WW-1:0]   wrap_cnt, wrap_cnt_n;
    logic            blink_phase, blink_phase_n;
    logic [2:0]      cur_digit_n;
    logic [7:0]      an_n;
    logic [5:0]      dec_data_n;
    logic            scan_wrap_n;

    logic [4:0]      num_arr [8];
    logic [2:0]      hi_idx, lo_idx, sel;
    logic            hi_found;
    logic            wrap;

    for (genvar g = 0; g < 8; g++) begin : g_unpack
        assign num_arr[g] = numbers[5*g +: 5];
    end

    // Next digit: lowest enabled index above cur_digit, else lowest enabled
    // overall. Scanning downward lets the lowest match win.
    always_comb begin
        hi_idx   = 3'd0;
        lo_idx   = 3'd0;
        hi_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (digen[i]) begin
                lo_idx = 3'(i);
                if (3'(i) > cur_digit) begin
                    hi_idx   = 3'(i);
                    hi_found = 1'b1;
                end
            end
        end
        sel  = hi_found ? hi_idx : lo_idx;
        wrap = (sel <= cur_digit);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_BLANK;
            cnt         <= '0;
            wrap_cnt    <= '0;
            blink_phase <= 1'b0;
            cur_digit   <= 3'd7;
            an          <= 8'hFF;
            dec_data    <= 6'h3F;
            scan_wrap   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            wrap_cnt    <= wrap_cnt_n;
            blink_phase <= blink_phase_n;
            cur_digit   <= cur_digit_n;
            an          <= an_n;
            dec_data    <= dec_data_n;
            scan_wrap   <= scan_wrap_n;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        wrap_cnt_n    = wrap_cnt;
        blink_phase_n = blink_phase;
        cur_digit_n   = cur_digit;
        an_n          = an;
        dec_data_n    = dec_data;
        scan_wrap_n   = 1'b0;

        case (state)
            ST_BLANK: begin
                an_n       = 8'hFF;
                dec_data_n = 6'h3F;
                if (cnt == BLANK_LAST) begin
                    cnt_n = '0;
                    if (digen == 8'h00) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n     = ST_SHOW;
                        cur_digit_n = sel;
                        scan_wrap_n = wrap;
                        if (wrap) begin
                            if (wrap_cnt == WRAP_LAST) begin
                                wrap_cnt_n    = '0;
                                blink_phase_n = ~blink_phase;
                            end else begin
                                wrap_cnt_n = wrap_cnt + 1'b1;
                            end
                        end
                        // The slot uses the phase in force before this wrap's
                        // toggle; the registered outputs then hold for the slot.
                        if (!(blink[sel] && blink_phase)) begin
                            an_n       = ~(8'h01 << sel);
                            dec_data_n = {dp_n[sel], num_arr[sel]};
                        end
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            ST_SHOW: begin
                if (!digen[cur_digit] || (cnt == SHOW_LAST)) begin
                    state_n    = ST_BLANK;
                    cnt_n      = '0;
                    an_n       = 8'hFF;
                    dec_data_n = 6'h3F;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            ST_IDLE: begin
                an_n       = 8'hFF;
                dec_data_n = 6'h3F;
                if (digen != 8'h00) begin
                    state_n = ST_BLANK;
                    cnt_n   = '0;
                end
            end

            default: begin
                state_n    = ST_BLANK;
                cnt_n      = '0;
                an_n       = 8'hFF;
                dec_data_n = 6'h3F;
            end
        endcase
    end

endmodule

// File: tb/tb_mfp_ahb_sevenseg_scan.sv
// -----------------------------------------------------------------------------
// tb_mfp_ahb_sevenseg_scan
//
// Directed and randomized stimulus against a slot-level reference model.
// A slot is a gap of BLANK cycles followed by SHOW cycles. The next digit is
// found by stepping forward modulo 8. The blink phase is derived from the
// running total of wraps: phase = (wraps before this slot / BS) mod 2.
// -----------------------------------------------------------------------------
module tb_mfp_ahb_sevenseg_scan;

    localparam int PS    = 8;
    localparam int BL    = 2;
    localparam int BS    = 2;
    localparam int SHOWN = PS - BL;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  digen;
    logic [39:0] numbers;
    logic [7:0]  dp_n;
    logic [7:0]  blink;
    logic [7:0]  an;
    logic [5:0]  dec_data;
    logic        scan_wrap;
    logic [2:0]  cur_digit;

    int total = 0;
    int bad   = 0;

    mfp_ahb_sevenseg_scan #(
        .PRESCALE    (PS),
        .BLANK_CYCLES(BL),
        .BLINK_SCANS (BS)
    ) dut (
        .clk      (clk),
        .reset    (rst),
        .digen    (digen),
        .numbers  (numbers),
        .dp_n     (dp_n),
        .blink    (blink),
        .an       (an),
        .dec_data (dec_data),
        .scan_wrap(scan_wrap),
        .cur_digit(cur_digit)
    );

    always #5 clk = ~clk;

    // reference model: mode 0 = gap, 1 = digit window, 2 = nothing enabled
    int         m_mode;
    int         m_t;
    int         m_wraps;
    logic [2:0] m_cur;
    logic [7:0] e_an;
    logic [5:0] e_dec;
    logic       e_wrap;
    logic [2:0] e_cur;

    task automatic model_reset();
        m_mode  = 0;
        m_t     = 0;
        m_wraps = 0;
        m_cur   = 3'd7;
        e_an    = 8'hFF;
        e_dec   = 6'h3F;
        e_wrap  = 1'b0;
        e_cur   = 3'd7;
    endtask

    task automatic model_step();
        logic [2:0] cand;
        logic       found;
        logic       wr;
        logic       dark;
        e_wrap = 1'b0;
        if (m_mode == 0) begin
            e_an  = 8'hFF;
            e_dec = 6'h3F;
            if (m_t == BL - 1) begin
                m_t = 0;
                if (digen == 8'h00) begin
                    m_mode = 2;
                end else begin
                    found = 1'b0;
                    cand  = m_cur;
                    for (int k = 1; k <= 8; k++) begin
                        if (!found && digen[m_cur + 3'(k)]) begin
                            cand  = m_cur + 3'(k);
                            found = 1'b1;
                        end
                    end
                    wr   = (cand <= m_cur);
                    dark = blink[cand] && (((m_wraps / BS) % 2) == 1);
                    if (wr) m_wraps++;
                    m_cur  = cand;
                    e_wrap = wr;
                    if (!dark) begin
                        e_an  = ~(8'd1 << cand);
                        e_dec = {dp_n[cand], 5'(numbers >> (5 * int'(cand)))};
                    end
                    m_mode = 1;
                end
            end else begin
                m_t++;
            end
        end else if (m_mode == 1) begin
            if (!digen[m_cur] || m_t == SHOWN - 1) begin
                m_mode = 0;
                m_t    = 0;
                e_an   = 8'hFF;
                e_dec  = 6'h3F;
            end else begin
                m_t++;
            end
        end else begin
            e_an  = 8'hFF;
            e_dec = 6'h3F;
            if (digen != 8'h00) begin
                m_mode = 0;
                m_t    = 0;
            end
        end
        e_cur = m_cur;
    endtask

    task automatic check();
        total++;
        assert (an === e_an) else begin
            bad++;
            $error("FAIL an got=%h exp=%h at %0t", an, e_an, $time);
        end
        total++;
        assert (dec_data === e_dec) else begin
            bad++;
            $error("FAIL dec_data got=%h exp=%h at %0t", dec_data, e_dec, $time);
        end
        total++;
        assert (scan_wrap === e_wrap) else begin
            bad++;
            $error("FAIL scan_wrap got=%b exp=%b at %0t", scan_wrap, e_wrap, $time);
        end
        total++;
        assert (cur_digit === e_cur) else begin
            bad++;
            $error("FAIL cur_digit got=%0d exp=%0d at %0t", cur_digit, e_cur, $time);
        end
        total++;
        assert (($countones(~an) <= 1) === 1'b1) else begin
            bad++;
            $error("FAIL one_hot_an got=%h exp=at_most_one_low at %0t", an, $time);
        end
    endtask

    // one clock: model follows the edge, outputs compared on the falling edge
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        check();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // bounded wait until the model shows digit d at window cycle t
    task automatic wait_show(input logic [2:0] d, input int t);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            if (m_mode == 1 && m_cur == d && m_t == t) hit = 1'b1;
            else tick();
        end
        total++;
        assert (hit === 1'b1) else begin
            bad++;
            $error("FAIL wait_show digit=%0d got=timeout exp=reached", d);
        end
    endtask

    task automatic set_digit(input int d, input logic [4:0] v);
        logic [39:0] mask;
        mask    = 40'h1F << (5 * d);
        numbers = (numbers & ~mask) | (40'(v) << (5 * d));
    endtask

    initial begin
        rst     = 1'b1;
        digen   = 8'hFF;
        dp_n    = 8'hA5;
        blink   = 8'h00;
        numbers = '0;
        for (int i = 0; i < 8; i++) set_digit(i, 5'(i));
        model_reset();
        #1;
        check();
        run(2);
        rst = 1'b0;

        // full scan, code i on digit i
        run(3 * 8 * PS);

        // two digits, each slot of digit 2 wraps
        digen = 8'b0010_0100;
        run(8 * PS + 3);

        // single blinking digit: two slots visible, two dark
        digen = 8'h10;
        blink = 8'h10;
        run(10 * PS);
        blink = 8'h00;

        // drop all enables in the middle of digit 3, then re-enable digit 0
        digen = 8'hFF;
        wait_show(3'd3, 2);
        digen = 8'h00;
        run(3 * PS);
        digen = 8'h01;
        run(3 * PS);

        // snapshot: change digit 3 code mid-window
        digen = 8'hFF;
        set_digit(3, 5'd5);
        wait_show(3'd3, 1);
        set_digit(3, 5'd9);
        run(9 * PS);

        // asynchronous reset during digit 6
        digen = 8'b0110_0110;
        wait_show(3'd6, 2);
        rst = 1'b1;
        #1;
        model_reset();
        check();
        run(2);
        rst = 1'b0;
        run(3 * PS);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                digen = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            end
            if ($urandom_range(0, 19) == 0) numbers = {8'($urandom), 32'($urandom)};
            if ($urandom_range(0, 39) == 0) dp_n = 8'($urandom);
            if ($urandom_range(0, 49) == 0) blink = 8'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                check();
                tick();
                rst = 1'b0;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
